// File: rtl/jtcps2_obj_scan_if.sv
// Bus between the CPS2 object scanner, the frame object table RAM and the object line renderer.
// The master side is the scanner.
interface jtcps2_obj_scan_if #(
    parameter int AW = 10,
    parameter int XW = 9
);
    logic [AW-1:0] table_addr;
    logic [15:0]   table_x;
    logic [15:0]   table_y;
    logic [15:0]   table_code;
    logic [15:0]   table_attr;
    logic          dr_start;
    logic          dr_idle;
    logic [15:0]   dr_code;
    logic [15:0]   dr_attr;
    logic [XW-1:0] dr_hpos;

    modport master (
        output table_addr,
        input  table_x, table_y, table_code, table_attr,
        output dr_start, dr_code, dr_attr, dr_hpos,
        input  dr_idle
    );

    modport slave (
        input  table_addr,
        output table_x, table_y, table_code, table_attr,
        input  dr_start, dr_code, dr_attr, dr_hpos,
        output dr_idle
    );
endinterface

// File: rtl/jtcps2_obj_scan.sv
// CPS2 per-line sprite scanner: walks the object table top-down and expands visible sprites into 16-pixel tile requests.
// Optional: define JTCPS2_OBJ_ENDMARK_EN so that attr[15:8]==8'hFF ends the scan.
module jtcps2_obj_scan #(
    parameter int AW     = 10,
    parameter int XW     = 9,
    parameter int BUDGET = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       flip,
    input  logic [8:0] vrender,
    input  logic       start,
    output logic       busy,
    output logic       overflow,
    jtcps2_obj_scan_if.master bus
);
    typedef enum logic [2:0] {S_IDLE, S_READ, S_EVAL, S_ISSUE, S_ACK} state_t;

    function automatic logic [15:0] tile_code(input logic [15:0] code,
                                              input logic [3:0]  m,
                                              input logic [3:0]  n);
        logic [3:0] hi;
        logic [3:0] lo;
        hi = code[7:4] + m;
        lo = code[3:0] + n;
        return {code[15:8], hi, lo};
    endfunction

    function automatic logic [XW-1:0] tile_hpos(input logic [XW-1:0] x,
                                                input logic [3:0]    npos);
        return x + XW'({npos, 4'h0}) - XW'(1);
    endfunction

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic          busy_q, busy_d;
    logic          first_q, first_d;
    logic          dr_start_q, dr_start_d;
    logic [15:0]   dr_code_q, dr_code_d;
    logic [15:0]   dr_attr_q, dr_attr_d;
    logic [XW-1:0] dr_hpos_q, dr_hpos_d;

    logic [8:0]    vrf_q, vrf_d;
    logic [15:0]   prev_x_q, prev_x_d, prev_y_q, prev_y_d;
    logic [15:0]   prev_code_q, prev_code_d, prev_attr_q, prev_attr_d;
    logic [XW-1:0] ent_x_q, ent_x_d;
    logic [15:0]   ent_code_q, ent_code_d;
    logic [7:0]    ent_attr_q, ent_attr_d;
    logic [3:0]    ent_n_q, ent_n_d;
    logic          ent_hflip_q, ent_hflip_d;
    logic [3:0]    m_q, m_d, row_q, row_d, n_q, n_d, npos_q, npos_d;

    // Entry evaluation, valid while in EVAL (table words arrive one cycle after the address)
    logic [8:0] vsub;
    logic [3:0] tm_in, tn_in, m_raw, m_eval, row_eval;
    logic       vflip_in, hflip_in, in_zone, is_repeat, skip, last_entry;
    logic [9:0] zone_lim;

    assign vsub       = vrf_q - bus.table_y[8:0];
    assign tm_in      = bus.table_attr[15:12];
    assign tn_in      = bus.table_attr[11:8];
    assign vflip_in   = bus.table_attr[6];
    assign hflip_in   = bus.table_attr[5];
    assign zone_lim   = {2'b00, tm_in, 4'h0} + 10'd16;
    assign in_zone    = {1'b0, vsub} < zone_lim;
    assign m_raw      = vsub[7:4];
    assign m_eval     = vflip_in ? (tm_in - m_raw) : m_raw;
    assign row_eval   = vsub[3:0] ^ {4{vflip_in}};
    assign is_repeat  = !first_q &&
                        bus.table_x    == prev_x_q    && bus.table_y    == prev_y_q &&
                        bus.table_code == prev_code_q && bus.table_attr == prev_attr_q;
    assign skip       = bus.table_y[15] || !in_zone || is_repeat;
    assign last_entry = (addr_q == '0);

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        busy_d      = busy_q;
        first_d     = first_q;
        dr_start_d  = 1'b0;
        dr_code_d   = dr_code_q;
        dr_attr_d   = dr_attr_q;
        dr_hpos_d   = dr_hpos_q;
        vrf_d       = vrf_q;
        prev_x_d    = prev_x_q;
        prev_y_d    = prev_y_q;
        prev_code_d = prev_code_q;
        prev_attr_d = prev_attr_q;
        ent_x_d     = ent_x_q;
        ent_code_d  = ent_code_q;
        ent_attr_d  = ent_attr_q;
        ent_n_d     = ent_n_q;
        ent_hflip_d = ent_hflip_q;
        m_d         = m_q;
        row_d       = row_q;
        n_d         = n_q;
        npos_d      = npos_q;

        // start wins in every state: a running scan is abandoned and restarted
        if (start) begin
            vrf_d   = vrender ^ {1'b0, {8{flip}}};
            addr_d  = '1;
            cnt_d   = '0;
            ovf_d   = 1'b0;
            first_d = 1'b1;
            busy_d  = 1'b1;
            state_d = S_READ;
        end else begin
            case (state_q)
                S_IDLE: busy_d = 1'b0;
                S_READ: state_d = S_EVAL;
                S_EVAL: begin
                    first_d     = 1'b0;
                    prev_x_d    = bus.table_x;
                    prev_y_d    = bus.table_y;
                    prev_code_d = bus.table_code;
                    prev_attr_d = bus.table_attr;
`ifdef JTCPS2_OBJ_ENDMARK_EN
                    if (bus.table_attr[15:8] == 8'hFF) begin
                        state_d = S_IDLE;
                    end else
`endif
                    if (skip) begin
                        if (last_entry) begin
                            state_d = S_IDLE;
                        end else begin
                            addr_d  = addr_q - AW'(1);
                            state_d = S_READ;
                        end
                    end else begin
                        ent_x_d     = bus.table_x[XW-1:0];
                        ent_code_d  = bus.table_code;
                        ent_attr_d  = bus.table_attr[7:0];
                        ent_n_d     = tn_in;
                        ent_hflip_d = hflip_in;
                        m_d         = m_eval;
                        row_d       = row_eval;
                        n_d         = 4'd0;
                        npos_d      = hflip_in ? tn_in : 4'd0;
                        state_d     = S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (bus.dr_idle) begin
                        dr_code_d  = tile_code(ent_code_q, m_q, n_q);
                        dr_attr_d  = {4'd0, row_q, ent_attr_q};
                        dr_hpos_d  = tile_hpos(ent_x_q, npos_q);
                        dr_start_d = 1'b1;
                        cnt_d      = cnt_q + 8'd1;
                        state_d    = S_ACK;
                    end
                end
                S_ACK: begin
                    if (cnt_q == 8'(BUDGET)) begin
                        ovf_d   = 1'b1;
                        state_d = S_IDLE;
                    end else if (n_q != ent_n_q) begin
                        n_d     = n_q + 4'd1;
                        npos_d  = ent_hflip_q ? (npos_q - 4'd1) : (npos_q + 4'd1);
                        state_d = S_ISSUE;
                    end else if (last_entry) begin
                        state_d = S_IDLE;
                    end else begin
                        addr_d  = addr_q - AW'(1);
                        state_d = S_READ;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            addr_q     <= '1;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            busy_q     <= 1'b0;
            first_q    <= 1'b1;
            dr_start_q <= 1'b0;
            dr_code_q  <= '0;
            dr_attr_q  <= '0;
            dr_hpos_q  <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            busy_q     <= busy_d;
            first_q    <= first_d;
            dr_start_q <= dr_start_d;
            dr_code_q  <= dr_code_d;
            dr_attr_q  <= dr_attr_d;
            dr_hpos_q  <= dr_hpos_d;
        end
    end

    // Datapath holding registers: only meaningful once the FSM has loaded them
    always_ff @(posedge clk) begin
        vrf_q       <= vrf_d;
        prev_x_q    <= prev_x_d;
        prev_y_q    <= prev_y_d;
        prev_code_q <= prev_code_d;
        prev_attr_q <= prev_attr_d;
        ent_x_q     <= ent_x_d;
        ent_code_q  <= ent_code_d;
        ent_attr_q  <= ent_attr_d;
        ent_n_q     <= ent_n_d;
        ent_hflip_q <= ent_hflip_d;
        m_q         <= m_d;
        row_q       <= row_d;
        n_q         <= n_d;
        npos_q      <= npos_d;
    end

    assign bus.table_addr = addr_q;
    assign bus.dr_start   = dr_start_q;
    assign bus.dr_code    = dr_code_q;
    assign bus.dr_attr    = dr_attr_q;
    assign bus.dr_hpos    = dr_hpos_q;
    assign busy           = busy_q;
    assign overflow       = ovf_q;
endmodule

// File: tb/tb_jtcps2_obj_scan.sv
// Directed bench for jtcps2_obj_scan: table RAM model, request monitor and one task per scenario.
module tb_jtcps2_obj_scan;
    localparam int AW = 10;
    localparam int XW = 9;
    localparam int BUDGET = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       flip;
    logic [8:0] vrender;
    logic       start;
    logic       busy;
    logic       overflow;

    int checks = 0;
    int errors = 0;

    jtcps2_obj_scan_if #(.AW(AW), .XW(XW)) bus ();

    jtcps2_obj_scan #(.AW(AW), .XW(XW), .BUDGET(BUDGET)) dut (
        .clk      (clk),
        .rst      (rst),
        .flip     (flip),
        .vrender  (vrender),
        .start    (start),
        .busy     (busy),
        .overflow (overflow),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    logic [15:0] tx [1024];
    logic [15:0] ty [1024];
    logic [15:0] tcode [1024];
    logic [15:0] tattr [1024];

    always_ff @(posedge clk) begin
        bus.table_x    <= tx[bus.table_addr];
        bus.table_y    <= ty[bus.table_addr];
        bus.table_code <= tcode[bus.table_addr];
        bus.table_attr <= tattr[bus.table_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          rq_total = 0;
    logic [15:0] rq_code [256];
    logic [15:0] rq_attr [256];
    logic [8:0]  rq_hpos [256];
    int          rq_cyc  [256];

    always @(negedge clk) begin
        if (bus.dr_start) begin
            rq_code[rq_total % 256] = bus.dr_code;
            rq_attr[rq_total % 256] = bus.dr_attr;
            rq_hpos[rq_total % 256] = bus.dr_hpos;
            rq_cyc[rq_total % 256]  = cyc;
            rq_total = rq_total + 1;
        end
    end

    int t_start;

    task automatic clear_table();
        for (int i = 0; i < 1024; i++) begin
            tx[i] = 16'h0000; ty[i] = 16'h8000; tcode[i] = 16'h0000; tattr[i] = 16'h0000;
        end
    endtask

    task automatic put(input int a, input logic [15:0] x, input logic [15:0] y,
                       input logic [15:0] c, input logic [15:0] at);
        tx[a] = x; ty[a] = y; tcode[a] = c; tattr[a] = at;
    endtask

    task automatic do_start(input logic [8:0] v);
        @(negedge clk);
        vrender = v;
        start = 1'b1;
        t_start = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit, input string name, output int n);
        n = 0;
        while (busy && n < limit) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (n >= limit) begin
            errors++;
            $display("FAIL %s timeout: busy still high after %0d cycles", name, n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; flip = 1'b0; start = 1'b0; vrender = '0; bus.dr_idle = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.table_addr !== 10'h3FF || bus.dr_start !== 1'b0 || bus.dr_code !== 16'h0 ||
            bus.dr_attr !== 16'h0 || bus.dr_hpos !== 9'h0 || busy !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset: addr=%h start=%b code=%h attr=%h hpos=%h busy=%b ovf=%b, required 3ff/0/0/0/0/0/0",
                     bus.table_addr, bus.dr_start, bus.dr_code, bus.dr_attr, bus.dr_hpos, busy, overflow);
        end
    endtask

    task automatic test_disabled_scan();
        int n, base;
        clear_table();
        base = rq_total;
        do_start(9'd0);
        wait_done(5000, "disabled_scan", n);
        checks++;
        if (n != 2049) begin errors++; $display("FAIL disabled_scan_busy: %0d cycles, required 2049", n); end
        checks++;
        if (rq_total != base) begin errors++; $display("FAIL disabled_scan_reqs: %0d, required 0", rq_total - base); end
    endtask

    task automatic test_single();
        int n, base;
        clear_table();
        put(1023, 16'd50, 16'd100, 16'h1230, 16'h0000);
        base = rq_total;
        do_start(9'd105);
        wait_done(5000, "single", n);
        checks++;
        if (rq_total - base != 1) begin
            errors++; $display("FAIL single_count: %0d, required 1", rq_total - base);
        end else begin
            checks++;
            if (rq_code[base % 256] !== 16'h1230) begin errors++; $display("FAIL single_code: %h, required 1230", rq_code[base % 256]); end
            checks++;
            if (rq_hpos[base % 256] !== 9'd49) begin errors++; $display("FAIL single_hpos: %0d, required 49", rq_hpos[base % 256]); end
            checks++;
            if (rq_attr[base % 256] !== 16'h0500) begin errors++; $display("FAIL single_attr: %h, required 0500", rq_attr[base % 256]); end
            checks++;
            if (rq_cyc[base % 256] - t_start != 4) begin
                errors++; $display("FAIL single_latency: %0d, required 4", rq_cyc[base % 256] - t_start);
            end
        end
        checks++;
        if (n != 2051) begin errors++; $display("FAIL single_busy: %0d cycles, required 2051", n); end
    endtask

    task automatic test_multi_flip();
        int n, base;
        logic [15:0] exp_code [3];
        logic [8:0]  exp_hpos [3];
        exp_code[0] = 16'h0040; exp_code[1] = 16'h0041; exp_code[2] = 16'h0042;
        exp_hpos[0] = 9'd47;    exp_hpos[1] = 9'd31;    exp_hpos[2] = 9'd15;
        clear_table();
        put(1023, 16'd16, 16'd0, 16'h0040, 16'h1260);
        base = rq_total;
        do_start(9'd20);
        wait_done(5000, "multi", n);
        checks++;
        if (rq_total - base != 3) begin
            errors++; $display("FAIL multi_count: %0d, required 3", rq_total - base);
        end else begin
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (rq_code[(base + k) % 256] !== exp_code[k] || rq_hpos[(base + k) % 256] !== exp_hpos[k] ||
                    rq_attr[(base + k) % 256] !== 16'h0B60) begin
                    errors++;
                    $display("FAIL multi_tile%0d: code=%h hpos=%0d attr=%h, required %h/%0d/0b60", k,
                             rq_code[(base + k) % 256], rq_hpos[(base + k) % 256], rq_attr[(base + k) % 256],
                             exp_code[k], exp_hpos[k]);
                end
            end
            checks++;
            if (rq_cyc[(base + 1) % 256] - rq_cyc[base % 256] != 2 || rq_cyc[(base + 2) % 256] - rq_cyc[(base + 1) % 256] != 2) begin
                errors++; $display("FAIL multi_spacing: %0d/%0d, required 2/2",
                    rq_cyc[(base + 1) % 256] - rq_cyc[base % 256], rq_cyc[(base + 2) % 256] - rq_cyc[(base + 1) % 256]);
            end
        end
    endtask

    task automatic test_wrap();
        int n, base;
        clear_table();
        put(1023, 16'd0, 16'd500, 16'h0100, 16'h1000);
        base = rq_total;
        do_start(9'd10);
        wait_done(5000, "wrap_in", n);
        checks++;
        if (rq_total - base != 1) begin
            errors++; $display("FAIL wrap_in_count: %0d, required 1", rq_total - base);
        end else begin
            checks++;
            if (rq_code[base % 256] !== 16'h0110 || rq_attr[base % 256] !== 16'h0600 || rq_hpos[base % 256] !== 9'd511) begin
                errors++; $display("FAIL wrap_in_tile: code=%h attr=%h hpos=%0d, required 0110/0600/511",
                                   rq_code[base % 256], rq_attr[base % 256], rq_hpos[base % 256]);
            end
        end
        base = rq_total;
        do_start(9'd30);
        wait_done(5000, "wrap_out", n);
        checks++;
        if (rq_total != base) begin errors++; $display("FAIL wrap_out_count: %0d, required 0", rq_total - base); end
    endtask

    task automatic test_repeat();
        int n, base;
        clear_table();
        put(1023, 16'd50, 16'd100, 16'h1230, 16'h0000);
        put(1022, 16'd50, 16'd100, 16'h1230, 16'h0000);
        put(1021, 16'd80, 16'h8064, 16'h2000, 16'h0000);
        base = rq_total;
        do_start(9'd105);
        wait_done(5000, "repeat", n);
        checks++;
        if (rq_total - base != 1) begin errors++; $display("FAIL repeat_count: %0d, required 1", rq_total - base); end
    endtask

    task automatic test_budget();
        int n, base;
        clear_table();
        for (int i = 0; i < 10; i++) put(1023 - i, 16'(10 * i + 20), 16'd100, 16'h0300, 16'h0000);
        base = rq_total;
        do_start(9'd105);
        wait_done(300, "budget", n);
        checks++;
        if (rq_total - base != 4) begin errors++; $display("FAIL budget_count: %0d, required 4", rq_total - base); end
        checks++;
        if (overflow !== 1'b1) begin errors++; $display("FAIL budget_overflow: %b, required 1", overflow); end
        checks++;
        if (n != 17) begin errors++; $display("FAIL budget_busy: %0d cycles, required 17", n); end
        do_start(9'd105);
        checks++;
        if (overflow !== 1'b0) begin errors++; $display("FAIL budget_ovf_clear: %b, required 0", overflow); end
        wait_done(300, "budget_again", n);
    endtask

    task automatic test_idle_low();
        int n, base;
        clear_table();
        put(1010, 16'd50, 16'd100, 16'h1230, 16'h0000);
        bus.dr_idle = 1'b0;
        base = rq_total;
        do_start(9'd105);
        repeat (40) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || rq_total != base || bus.table_addr !== 10'd1010) begin
            errors++; $display("FAIL idle_hold: busy=%b reqs=%0d addr=%0d, required 1/0/1010", busy, rq_total - base, bus.table_addr);
        end
        do_start(9'd105);
        checks++;
        if (bus.table_addr !== 10'd1023 || rq_total != base) begin
            errors++; $display("FAIL idle_restart: addr=%0d reqs=%0d, required 1023/0", bus.table_addr, rq_total - base);
        end
        bus.dr_idle = 1'b1;
        wait_done(5000, "idle_resume", n);
        checks++;
        if (rq_total - base != 1) begin errors++; $display("FAIL idle_resume_count: %0d, required 1", rq_total - base); end
    endtask

    task automatic test_endmark();
        int n, base;
        clear_table();
        put(1000, 16'd0, 16'h8000, 16'h0000, 16'hFF00);
        put(999, 16'd50, 16'd100, 16'h1230, 16'h0000);
        base = rq_total;
        do_start(9'd105);
        wait_done(5000, "endmark", n);
`ifdef JTCPS2_OBJ_ENDMARK_EN
        checks++;
        if (rq_total != base) begin errors++; $display("FAIL endmark_count: %0d, required 0", rq_total - base); end
        checks++;
        if (n != 49) begin errors++; $display("FAIL endmark_busy: %0d cycles, required 49", n); end
`else
        checks++;
        if (rq_total - base != 1) begin errors++; $display("FAIL endmark_off_count: %0d, required 1", rq_total - base); end
        checks++;
        if (n != 2051) begin errors++; $display("FAIL endmark_off_busy: %0d cycles, required 2051", n); end
`endif
    endtask

    initial begin
        test_reset();
        test_disabled_scan();
        test_single();
        test_multi_flip();
        test_wrap();
        test_repeat();
        test_budget();
        test_idle_low();
        test_endmark();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
